// File: rtl/mult_frac_pipe.sv
// Fracturable WIDTH x WIDTH multiplier with valid/ready flow control: one full-width product,
// two half-width lanes or four quarter-width lanes per beat, PIPE_STAGES cycles of latency.
module mult_frac_pipe #(
   parameter int unsigned WIDTH       = 36,
   parameter int unsigned PIPE_STAGES = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [0:WIDTH-1]   a,
   input  logic [0:WIDTH-1]   b,
   input  logic [0:1]         mode,
   input  logic               is_signed,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [0:2*WIDTH-1] out,
   output logic [0:1]         out_mode
);

   localparam int unsigned Q           = WIDTH / 4;
   localparam int unsigned PpW         = 2 * Q + 2;
   localparam int unsigned PW          = 2 * WIDTH;
   localparam int unsigned FrontStages = (PIPE_STAGES >= 3) ? 2 : PIPE_STAGES - 1;
   localparam int unsigned ResStages   = PIPE_STAGES - FrontStages;
   localparam logic [1:0]  ModeQuad    = 2'b01;
   localparam logic [1:0]  ModeHalf    = 2'b10;

   typedef logic [15:0][PpW-1:0] pp_t;

   // Operands are split into four Q-bit digits (digit 0 = MSB). A digit is treated as signed
   // only when it is the top digit of a signed lane in the current mode, so one set of 16
   // digit products serves every lane split.
   function automatic pp_t gen_pp(logic [WIDTH-1:0] av, logic [WIDTH-1:0] bv,
                                  logic [1:0] md, logic sgn);
      pp_t                   pp;
      logic [3:0]            sd;
      logic signed [Q:0]     ad;
      logic signed [Q:0]     bd;
      logic signed [PpW-1:0] ax;
      logic signed [PpW-1:0] bx;
      for (int i = 0; i < 4; i++) begin
         sd[i] = sgn && (i == 0 || md == ModeQuad || (md == ModeHalf && i == 2));
      end
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            ad = {sd[i] & av[WIDTH-1-i*Q], av[WIDTH-1-i*Q -: Q]};
            bd = {sd[j] & bv[WIDTH-1-j*Q], bv[WIDTH-1-j*Q -: Q]};
            ax = {{(PpW-Q-1){ad[Q]}}, ad};
            bx = {{(PpW-Q-1){bd[Q]}}, bd};
            pp[i*4+j] = ax * bx;
         end
      end
      return pp;
   endfunction

   function automatic logic [PW-1:0] sum_pp(pp_t pp, logic [1:0] md);
      logic [PW-1:0]    full;
      logic [WIDTH-1:0] half_hi;
      logic [WIDTH-1:0] half_lo;
      logic [PW-1:0]    res;
      full    = '0;
      half_hi = '0;
      half_lo = '0;
      for (int i = 0; i < 4; i++) begin
         for (int j = 0; j < 4; j++) begin
            full = full + ({{(PW-PpW){pp[i*4+j][PpW-1]}}, pp[i*4+j]} << (Q * (6 - i - j)));
            if (i < 2 && j < 2) begin
               half_hi = half_hi + ({{(WIDTH-PpW){pp[i*4+j][PpW-1]}}, pp[i*4+j]}
                                    << (Q * (2 - i - j)));
            end else if (i >= 2 && j >= 2) begin
               half_lo = half_lo + ({{(WIDTH-PpW){pp[i*4+j][PpW-1]}}, pp[i*4+j]}
                                    << (Q * (6 - i - j)));
            end
         end
      end
      unique case (md)
         ModeQuad: res = {pp[0][2*Q-1:0], pp[5][2*Q-1:0], pp[10][2*Q-1:0], pp[15][2*Q-1:0]};
         ModeHalf: res = {half_hi, half_lo};
         default:  res = full;
      endcase
      return res;
   endfunction

   logic [WIDTH-1:0] a_v;
   logic [WIDTH-1:0] b_v;
   logic [1:0]       mode_v;
   logic [PW-1:0]    res_in;
   logic [1:0]       mode_in;
   logic             valid_in;
   logic             advance;

   assign a_v    = a;
   assign b_v    = b;
   assign mode_v = mode;

   // Single global enable: every stage moves when the output slot is free or being drained.
   assign in_ready = !rst && (!out_valid || out_ready);
   assign advance  = in_ready;

   if (FrontStages == 0) begin : g_comb_front
      assign res_in   = sum_pp(gen_pp(a_v, b_v, mode_v, is_signed), mode_v);
      assign mode_in  = mode_v;
      assign valid_in = in_valid;
   end else begin : g_reg_front
      logic             v1_q;
      logic [WIDTH-1:0] a1_q;
      logic [WIDTH-1:0] b1_q;
      logic [1:0]       m1_q;
      logic             s1_q;

      always_ff @(posedge clk or posedge rst) begin
         if (rst) begin
            v1_q <= 1'b0;
            a1_q <= '0;
            b1_q <= '0;
            m1_q <= '0;
            s1_q <= 1'b0;
         end else if (advance) begin
            v1_q <= in_valid;
            if (in_valid) begin
               a1_q <= a_v;
               b1_q <= b_v;
               m1_q <= mode_v;
               s1_q <= is_signed;
            end
         end
      end

      if (FrontStages == 1) begin : g_sum_after_s1
         assign res_in   = sum_pp(gen_pp(a1_q, b1_q, m1_q, s1_q), m1_q);
         assign mode_in  = m1_q;
         assign valid_in = v1_q;
      end else begin : g_pp_stage
         logic       v2_q;
         pp_t        pp2_q;
         logic [1:0] m2_q;

         always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
               v2_q  <= 1'b0;
               pp2_q <= '0;
               m2_q  <= '0;
            end else if (advance) begin
               v2_q <= v1_q;
               if (v1_q) begin
                  pp2_q <= gen_pp(a1_q, b1_q, m1_q, s1_q);
                  m2_q  <= m1_q;
               end
            end
         end

         assign res_in   = sum_pp(pp2_q, m2_q);
         assign mode_in  = m2_q;
         assign valid_in = v2_q;
      end
   end

   // Result stages; data only loads behind a valid beat so out holds through bubbles.
   logic [ResStages-1:0]         rv_q;
   logic [ResStages-1:0][PW-1:0] res_q;
   logic [ResStages-1:0][1:0]    rm_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rv_q  <= '0;
         res_q <= '0;
         rm_q  <= '0;
      end else if (advance) begin
         rv_q[0] <= valid_in;
         if (valid_in) begin
            res_q[0] <= res_in;
            rm_q[0]  <= mode_in;
         end
         for (int k = 1; k < ResStages; k++) begin
            rv_q[k] <= rv_q[k-1];
            if (rv_q[k-1]) begin
               res_q[k] <= res_q[k-1];
               rm_q[k]  <= rm_q[k-1];
            end
         end
      end
   end

   assign out_valid = rv_q[ResStages-1];
   assign out       = res_q[ResStages-1];
   assign out_mode  = rm_q[ResStages-1];

endmodule

// File: tb/tb_mult_frac_pipe.sv
// Bench for mult_frac_pipe: 1-, 2- and 4-stage builds run side by side, each with its own driver,
// scoreboard queue and monitor, checked against a lane-arithmetic reference model.
module tb_mult_frac_pipe;

   localparam int unsigned W     = 36;
   localparam int unsigned NInst = 3;

   typedef struct packed {
      logic [2*W-1:0] data;
      logic [1:0]     mode;
   } exp_t;

   logic        clk = 1'b0;
   int unsigned cyc = 0;
   int          n_chk = 0;
   int          n_fail = 0;
   bit          done [NInst];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input int p, input string name, input logic [2*W-1:0] act,
                        input logic [2*W-1:0] req);
      n_chk++;
      if (act !== req) begin
         n_fail++;
         $display("FAIL P=%0d %s: got %h, expected %h", p, name, act, req);
      end
   endtask

   // Lane products from plain integer arithmetic on extracted, optionally sign-adjusted fields.
   function automatic logic [2*W-1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                            input logic [1:0] md, input logic sg);
      int                    n;
      int                    lw;
      logic [4*W-1:0]        ax;
      logic [4*W-1:0]        bx;
      logic [4*W-1:0]        one;
      logic [4*W-1:0]        m;
      logic [4*W-1:0]        m2;
      logic signed [4*W-1:0] x;
      logic signed [4*W-1:0] y;
      logic signed [4*W-1:0] p;
      logic [2*W-1:0]        r;
      n   = (md == 2'b01) ? 4 : (md == 2'b10) ? 2 : 1;
      lw  = W / n;
      ax  = {{(3*W){1'b0}}, av};
      bx  = {{(3*W){1'b0}}, bv};
      one = 1;
      m   = (one << lw) - one;
      m2  = (one << (2 * lw)) - one;
      r   = '0;
      for (int k = 0; k < n; k++) begin
         x = (ax >> (W - (k + 1) * lw)) & m;
         y = (bx >> (W - (k + 1) * lw)) & m;
         if (sg && x[lw-1]) x = x - (one << lw);
         if (sg && y[lw-1]) y = y - (one << lw);
         p = x * y;
         r = r | (2*W)'((p & m2) << ((n - 1 - k) * 2 * lw));
      end
      return r;
   endfunction

   function automatic logic [W-1:0] rand_op();
      logic [63:0]  r;
      logic [W-1:0] t;
      r = {$urandom, $urandom};
      case ($urandom_range(0, 5))
         0: t = '1;
         1: t = {4{9'h100}};
         2: t = '0;
         default: t = r[W-1:0];
      endcase
      return t;
   endfunction

   for (genvar gi = 0; gi < NInst; gi++) begin : g_inst
      localparam int unsigned P = (gi == 0) ? 1 : ((gi == 1) ? 2 : 4);

      logic           rst = 1'b1;
      logic           in_valid = 1'b0;
      logic           in_ready;
      logic [0:W-1]   a = '0;
      logic [0:W-1]   b = '0;
      logic [0:1]     mode = '0;
      logic           is_signed = 1'b0;
      logic           out_valid;
      logic           out_ready = 1'b0;
      logic [0:2*W-1] out;
      logic [0:1]     out_mode;
      exp_t           sb[$];
      logic           hold_v = 1'b0;
      logic [2*W-1:0] hold_d;
      logic [1:0]     hold_m;

      mult_frac_pipe #(
         .WIDTH       (W),
         .PIPE_STAGES (P)
      ) u_dut (
         .clk       (clk),
         .rst       (rst),
         .in_valid  (in_valid),
         .in_ready  (in_ready),
         .a         (a),
         .b         (b),
         .mode      (mode),
         .is_signed (is_signed),
         .out_valid (out_valid),
         .out_ready (out_ready),
         .out       (out),
         .out_mode  (out_mode)
      );

      always @(negedge clk) begin : g_mon
         exp_t e;
         if (rst) begin
            hold_v = 1'b0;
         end else begin
            check(P, "in_ready", (2*W)'(in_ready), (2*W)'(!out_valid || out_ready));
            if (hold_v) begin
               check(P, "stall_out", out, hold_d);
               check(P, "stall_mode", (2*W)'(out_mode), (2*W)'(hold_m));
            end
            hold_v = out_valid && !out_ready;
            hold_d = out;
            hold_m = out_mode;
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  n_chk++;
                  n_fail++;
                  $display("FAIL P=%0d unexpected_beat: got %h, expected no beat", P, out);
               end else begin
                  e = sb.pop_front();
                  check(P, "out", out, e.data);
                  check(P, "out_mode", (2*W)'(out_mode), (2*W)'(e.mode));
               end
            end
         end
      end

      task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [1:0] md,
                          input logic sg, input logic [2*W-1:0] ex, output int unsigned pres);
         int unsigned waited;
         waited    = 0;
         pres      = 0;
         a         = av;
         b         = bv;
         mode      = md;
         is_signed = sg;
         in_valid  = 1'b1;
         @(negedge clk);
         while (!in_ready && waited < 200) begin
            waited++;
            @(negedge clk);
         end
         if (in_ready) begin
            sb.push_back('{data: ex, mode: md});
            pres = cyc;
         end else begin
            n_chk++;
            n_fail++;
            $display("FAIL P=%0d accept_timeout: in_ready 0 for 200 cycles, expected 1", P);
         end
         @(posedge clk);
         #1;
         in_valid = 1'b0;
      endtask

      task automatic rsend(output int unsigned pres);
         logic [W-1:0] av;
         logic [W-1:0] bv;
         logic [1:0]   md;
         logic         sg;
         av = rand_op();
         bv = rand_op();
         md = 2'($urandom_range(0, 3));
         sg = 1'($urandom_range(0, 1));
         send(av, bv, md, sg, model(av, bv, md, sg), pres);
      endtask

      task automatic drain();
         int unsigned n;
         n = 0;
         while (sb.size() != 0 && n < 100) begin
            @(negedge clk);
            n++;
         end
         check(P, "drain_left", (2*W)'(sb.size()), '0);
         @(posedge clk);
         #1;
      endtask

      initial begin : g_drv
         int unsigned pres;
         int unsigned n;
         logic        stop_rnd;
         stop_rnd = 1'b0;
         repeat (3) @(posedge clk);
         #1;
         check(P, "rst_out_valid", (2*W)'(out_valid), '0);
         check(P, "rst_out", out, '0);
         check(P, "rst_out_mode", (2*W)'(out_mode), '0);
         check(P, "rst_in_ready", (2*W)'(in_ready), '0);
         rst = 1'b0;
         @(negedge clk);
         check(P, "post_rst_in_ready", (2*W)'(in_ready), (2*W)'(1));
         @(posedge clk);
         #1;
         out_ready = 1'b1;

         // Directed beats, back to back.
         send({9'd3, 9'd5, 9'd7, 9'd9}, {9'd3, 9'd5, 9'd7, 9'd9}, 2'b01, 1'b0,
              {18'd9, 18'd25, 18'd49, 18'd81}, pres);
         send({18'h3FFFE, 18'h3FFFF}, {18'd3, 18'h3FFFF}, 2'b10, 1'b1,
              {36'hFFFFFFFFA, 36'd1}, pres);
         send(36'hFFFFFFFFF, 36'hFFFFFFFFF, 2'b11, 1'b0, 72'hFFFFFFFFE000000001, pres);
         send(36'hFFFFFFFFF, 36'hFFFFFFFFF, 2'b11, 1'b1, 72'd1, pres);
         send(36'd123456, 36'd1000, 2'b00, 1'b0, 72'd123456000, pres);
         drain();

         // Latency from an empty pipe.
         rsend(pres);
         n = 0;
         do begin
            @(negedge clk);
            n++;
         end while (!out_valid && n < 20);
         check(P, "latency", (2*W)'(cyc - pres), (2*W)'(P));
         drain();

         // Alternating modes, then hold the output for five cycles.
         send({9'h1FF, 9'h100, 9'd5, 9'h1FE}, {9'd2, 9'h100, 9'h1FB, 9'h1FE}, 2'b01, 1'b1,
              {18'h3FFFE, 18'h10000, 18'h3FFE7, 18'd4}, pres);
         send({18'h3FFFF, 18'd1000}, {18'h3FFFF, 18'd3}, 2'b10, 1'b0,
              {36'hFFFF80001, 36'd3000}, pres);
         send(36'hFFFFFFFFE, 36'd7, 2'b00, 1'b1, 72'hFFFFFFFFFFFFFFFFF2, pres);
         out_ready = 1'b0;
         fork
            begin
               rsend(pres);
               rsend(pres);
               rsend(pres);
            end
            begin
               repeat (5) @(posedge clk);
               @(negedge clk);
               check(P, "stall_out_valid", (2*W)'(out_valid), (2*W)'(1));
               check(P, "stall_in_ready", (2*W)'(in_ready), '0);
               @(posedge clk);
               #1;
               out_ready = 1'b1;
            end
         join
         drain();

         // Reset with beats in flight: everything is discarded.
         rsend(pres);
         rsend(pres);
         rst = 1'b1;
         sb.delete();
         #1;
         check(P, "midrst_out_valid", (2*W)'(out_valid), '0);
         check(P, "midrst_out", out, '0);
         check(P, "midrst_out_mode", (2*W)'(out_mode), '0);
         check(P, "midrst_in_ready", (2*W)'(in_ready), '0);
         repeat (2) @(posedge clk);
         #1;
         rst = 1'b0;
         @(negedge clk);
         check(P, "midrst_release_in_ready", (2*W)'(in_ready), (2*W)'(1));
         @(posedge clk);
         #1;

         // Random beats with random backpressure.
         fork
            begin
               for (int i = 0; i < 150; i++) begin
                  repeat ($urandom_range(0, 1)) begin
                     @(posedge clk);
                     #1;
                  end
                  rsend(pres);
               end
               stop_rnd = 1'b1;
            end
            begin
               while (!stop_rnd) begin
                  @(posedge clk);
                  #1;
                  out_ready = ($urandom_range(0, 3) != 0);
               end
            end
         join
         out_ready = 1'b1;
         drain();
         repeat (3) @(posedge clk);
         done[gi] = 1'b1;
      end
   end

   initial begin
      fork
         wait (done[0] && done[1] && done[2]);
         begin
            #200000;
            n_chk++;
            n_fail++;
            $display("FAIL global_timeout: bench still running, expected completion");
         end
      join_any
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
